// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the two-requester I2C transaction arbiter.
package i2c_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DEV_W   = 7;
  localparam int unsigned REG_W   = 8;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; remembers the last granted requester.
module rr_arb2
  import i2c_arb_pkg::*;
(
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_upd,
  input  logic               i_upd_idx,
  output logic [NUM_REQ-1:0] o_sel_c,
  output logic               o_sel_idx_c,
  output logic               o_any_c
);

  logic r_last;

  // Pointer starts at 1 so requester 0 wins the first contest.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_upd) begin
      r_last <= i_upd_idx;
    end
  end

  always_comb begin
    o_any_c     = |i_req;
    o_sel_idx_c = 1'b0;
    if (i_req == 2'b11) begin
      o_sel_idx_c = ~r_last;
    end else if (i_req[1]) begin
      o_sel_idx_c = 1'b1;
    end
    o_sel_c = 2'b00;
    if (o_any_c) begin
      o_sel_c = o_sel_idx_c ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Arbitrates two requesters onto one I2C engine: latch, issue, wait (with timeout), respond.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         rw,
  input  logic [NUM_REQ*DEV_W-1:0]   dev_addr,
  input  logic [NUM_REQ*REG_W-1:0]   reg_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [DATA_W-1:0]          rdata,
  output logic                       err,
  output logic                       m_start,
  output logic                       m_rw,
  output logic [DEV_W-1:0]           m_dev_addr,
  output logic [REG_W-1:0]           m_reg_addr,
  output logic [DATA_W-1:0]          m_wdata,
  input  logic                       m_busy,
  input  logic                       m_done,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic                       m_ack_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]  r_done, w_done_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_err, w_err_nxt;
  logic                r_m_start, w_m_start_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_gidx;
  logic                r_m_rw;
  logic [DEV_W-1:0]    r_m_dev;
  logic [REG_W-1:0]    r_m_reg;
  logic [DATA_W-1:0]   r_m_wdata;
  logic                w_latch, w_upd, w_timeout;
  logic [NUM_REQ-1:0]  w_sel;
  logic                w_sel_idx, w_any;
  logic                w_rw;
  logic [DEV_W-1:0]    w_dev;
  logic [REG_W-1:0]    w_reg;
  logic [DATA_W-1:0]   w_wdata;

  rr_arb2 u_rr (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .i_req       (req),
    .i_upd       (w_upd),
    .i_upd_idx   (r_gidx),
    .o_sel_c     (w_sel),
    .o_sel_idx_c (w_sel_idx),
    .o_any_c     (w_any)
  );

  assign w_rw      = rw[w_sel_idx];
  assign w_dev     = w_sel_idx ? dev_addr[DEV_W +: DEV_W]   : dev_addr[0 +: DEV_W];
  assign w_reg     = w_sel_idx ? reg_addr[REG_W +: REG_W]   : reg_addr[0 +: REG_W];
  assign w_wdata   = w_sel_idx ? wdata[DATA_W +: DATA_W]    : wdata[0 +: DATA_W];
  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (!m_busy) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (m_done || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; m_done has priority over timeout.
  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_done_nxt    = '0;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = r_err;
    w_m_start_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_latch       = 1'b0;
    w_upd         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_nxt = w_sel;
          w_latch   = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (!m_busy) begin
          w_m_start_nxt = 1'b1;
          w_cnt_nxt     = '0;
        end
      end
      ST_WAIT: begin
        if (m_done) begin
          w_rdata_nxt = m_rdata;
          w_err_nxt   = m_ack_err;
          w_done_nxt  = r_gnt;
        end else if (w_timeout) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_done_nxt  = r_gnt;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_gnt_nxt = '0;
        w_upd     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_gnt     <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_m_start <= 1'b0;
      r_cnt     <= '0;
      r_gidx    <= 1'b0;
      r_m_rw    <= 1'b0;
      r_m_dev   <= '0;
      r_m_reg   <= '0;
      r_m_wdata <= '0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
      r_m_start <= w_m_start_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_latch) begin
        r_gidx    <= w_sel_idx;
        r_m_rw    <= w_rw;
        r_m_dev   <= w_dev;
        r_m_reg   <= w_reg;
        r_m_wdata <= w_wdata;
      end
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign rdata      = r_rdata;
  assign err        = r_err;
  assign m_start    = r_m_start;
  assign m_rw       = r_m_rw;
  assign m_dev_addr = r_m_dev;
  assign m_reg_addr = r_m_reg;
  assign m_wdata    = r_m_wdata;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter; a second instance uses a 16-cycle timeout.
module tb_i2c_req_arbiter;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [1:0]  req, rw;
  logic [13:0] dev_addr;
  logic [15:0] reg_addr, wdata;
  logic        m_busy, m_done, m_ack_err;
  logic [7:0]  m_rdata;

  logic [1:0]  gnt, done;
  logic [7:0]  rdata, m_wdata, m_reg_addr;
  logic        err, m_start, m_rw;
  logic [6:0]  m_dev_addr;

  logic [1:0]  to_gnt, to_done;
  logic [7:0]  to_rdata, to_m_wdata, to_m_reg_addr;
  logic        to_err, to_m_start, to_m_rw;
  logic [6:0]  to_m_dev_addr;

  int n_checks = 0;
  int n_err    = 0;
  int n_lat;

  always #5 sys_clk = ~sys_clk;

  i2c_req_arbiter dut (
    .sys_clk(sys_clk), .rst(rst), .req(req), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .gnt(gnt), .done(done), .rdata(rdata),
    .err(err), .m_start(m_start), .m_rw(m_rw), .m_dev_addr(m_dev_addr),
    .m_reg_addr(m_reg_addr), .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done),
    .m_rdata(m_rdata), .m_ack_err(m_ack_err)
  );

  i2c_req_arbiter #(.TIMEOUT_CYCLES(16)) dut_to (
    .sys_clk(sys_clk), .rst(rst), .req(req), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .gnt(to_gnt), .done(to_done), .rdata(to_rdata),
    .err(to_err), .m_start(to_m_start), .m_rw(to_m_rw), .m_dev_addr(to_m_dev_addr),
    .m_reg_addr(to_m_reg_addr), .m_wdata(to_m_wdata), .m_busy(m_busy), .m_done(m_done),
    .m_rdata(m_rdata), .m_ack_err(m_ack_err)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Grant, start, immediate engine completion, then the mandatory idle cycle.
  task automatic run_txn(input logic [1:0] exp_g, input string tag);
    tick();
    chk({tag, "_gnt"}, 64'(gnt), 64'(exp_g));
    tick();
    chk({tag, "_start"}, 64'(m_start), 64'd1);
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'(exp_g));
    tick();
    chk({tag, "_idle"}, 64'({gnt, done}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 2'b00; rw = 2'b00; dev_addr = '0; reg_addr = '0; wdata = '0;
    m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00;
    tick();
    tick();
    chk("reset_outs", 64'({gnt, done, rdata, err, m_start, m_rw, m_dev_addr, m_reg_addr, m_wdata}), 64'd0);
    chk("reset_outs_to", 64'({to_gnt, to_done, to_rdata, to_err, to_m_start, to_m_rw,
                              to_m_dev_addr, to_m_reg_addr, to_m_wdata}), 64'd0);
    rst = 1'b0;

    // Write from r0: dev 0x50, reg 0x00, wdata 0xA5, completes 20 cycles after start.
    req = 2'b01; rw = 2'b00; dev_addr = {7'h00, 7'h50}; reg_addr = 16'h0000; wdata = {8'h00, 8'hA5};
    tick();
    chk("w_gnt", 64'(gnt), 64'h1);
    chk("w_nostart_yet", 64'(m_start), 64'd0);
    tick();
    chk("w_start_lat2", 64'(m_start), 64'd1);
    chk("w_fields", 64'({m_rw, m_dev_addr, m_reg_addr, m_wdata}), 64'({1'b0, 7'h50, 8'h00, 8'hA5}));
    req = 2'b00;
    tick();
    chk("w_start_once", 64'(m_start), 64'd0);
    for (int i = 0; i < 18; i++) tick();
    chk("w_still_wait", 64'({gnt, done}), 64'({2'b01, 2'b00}));
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("w_done", 64'(done), 64'h1);
    chk("w_err", 64'({err, rdata}), 64'd0);
    tick();
    chk("w_resp_clear", 64'({gnt, done}), 64'd0);
    chk("w_fields_hold", 64'(m_wdata), 64'hA5);

    // Stray engine completion while idle must be ignored.
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    tick();
    chk("stray_done", 64'({gnt, done, m_start}), 64'd0);

    // Both requesting: strict alternation starting with r0.
    do_reset();
    req = 2'b11;
    run_txn(2'b01, "rr0");
    run_txn(2'b10, "rr1");
    run_txn(2'b01, "rr2");
    run_txn(2'b10, "rr3");

    // Read from r1 with NACK.
    req = 2'b10; rw = 2'b10; dev_addr = {7'h2A, 7'h11}; reg_addr = {8'h10, 8'h22}; wdata = {8'h33, 8'h44};
    tick();
    chk("r_gnt", 64'(gnt), 64'h2);
    tick();
    chk("r_start", 64'(m_start), 64'd1);
    chk("r_fields", 64'({m_rw, m_dev_addr, m_reg_addr, m_wdata}), 64'({1'b1, 7'h2A, 8'h10, 8'h33}));
    m_done = 1'b1; m_rdata = 8'h3C; m_ack_err = 1'b1;
    tick();
    m_done = 1'b0; m_rdata = 8'h00; m_ack_err = 1'b0; req = 2'b00;
    chk("r_done", 64'(done), 64'h2);
    chk("r_rdata_err", 64'({rdata, err}), 64'({8'h3C, 1'b1}));
    tick();
    tick();
    chk("r_hold", 64'({done, rdata, err}), 64'({2'b00, 8'h3C, 1'b1}));

    // Timeout instance: no m_done, done 16 cycles after m_start.
    do_reset();
    req = 2'b01; rw = 2'b00;
    tick();
    req = 2'b00;
    tick();
    chk("to_start", 64'(to_m_start), 64'd1);
    m_rdata = 8'h55;
    n_lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (to_done != 2'b00) begin
        n_lat = i;
        break;
      end
    end
    chk("to_latency", 64'(n_lat), 64'd16);
    chk("to_done", 64'(to_done), 64'h1);
    chk("to_err_rdata", 64'({to_err, to_rdata}), 64'({1'b1, 8'h00}));
    m_rdata = 8'h00;

    // Engine busy holds ISSUE; then reset abandons the transaction in WAIT.
    do_reset();
    req = 2'b01; m_busy = 1'b1;
    tick();
    req = 2'b00;
    chk("b_gnt", 64'(gnt), 64'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_hold_nostart", 64'({m_start, gnt}), 64'({1'b0, 2'b01}));
    end
    m_busy = 1'b0;
    tick();
    chk("b_start", 64'(m_start), 64'd1);
    tick();
    chk("b_start_once", 64'(m_start), 64'd0);
    rst = 1'b1;
    tick();
    chk("b_rst_outs", 64'({gnt, done, rdata, err, m_start, m_rw, m_dev_addr, m_reg_addr, m_wdata}), 64'd0);
    rst = 1'b0;
    tick();
    chk("b_no_done", 64'({gnt, done}), 64'd0);
    req = 2'b11;
    tick();
    chk("b_next_r0", 64'(gnt), 64'h1);
    req = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  TIMEOUT_CYCLES  120000  sys_clk cycles allowed from m_start to m_done before a transaction is aborted
  NUM_REQ  2  requester count; fixed, not overridable
REQ-002 Ports SHALL be, one per line (requester i occupies bits [i] or slice i):
  sys_clk  in  1  single clock
  rst  in  1  reset: synchronous, active-high
  req  in  2  per-requester level request
  rw  in  2  per-requester direction: 1=read, 0=write
  dev_addr  in  14  7-bit slave address per requester
  reg_addr  in  16  8-bit register address per requester
  wdata  in  16  8-bit write byte per requester
  gnt  out  2  one-hot grant, held for the whole transaction
  done  out  2  one-cycle completion pulse per requester
  rdata  out  8  read byte of the last completed transaction
  err  out  1  NACK or timeout flag of the last completed transaction
  m_start  out  1  one-cycle start pulse to the I2C engine
  m_rw  out  1  direction to engine
  m_dev_addr  out  7  slave address to engine
  m_reg_addr  out  8  register address to engine
  m_wdata  out  8  write byte to engine
  m_busy  in  1  engine busy
  m_done  in  1  engine one-cycle completion pulse
  m_rdata  in  8  engine read byte
  m_ack_err  in  1  engine NACK indication
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; no other states.
REQ-005 IDLE: when any req bit is 1, the block SHALL select one requester, latch that requester's rw/dev_addr/reg_addr/wdata, assert its gnt bit from the next cycle, and go to ISSUE.
REQ-006 Selection SHALL be round-robin: with both requests active, the requester not granted last wins; with one active, it wins.
REQ-007 ISSUE: if m_busy=0, m_start SHALL pulse for exactly one cycle and the FSM SHALL go to WAIT; if m_busy=1, the FSM SHALL stay in ISSUE with m_start=0.
REQ-008 m_rw/m_dev_addr/m_reg_addr/m_wdata SHALL drive the latched fields from ISSUE through WAIT and SHALL remain stable until the next latch.
REQ-009 WAIT: on m_done=1, the block SHALL capture m_rdata into rdata and m_ack_err into err, then go to RESP.
REQ-010 WAIT: a timeout counter SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES-1 without m_done, err SHALL be set to 1, rdata to 0x00, and the FSM SHALL go to RESP. Counter width SHALL be clog2(TIMEOUT_CYCLES).
REQ-011 m_done and timeout in the same cycle: m_done SHALL take precedence.
REQ-012 RESP: the granted requester's done bit SHALL pulse for one cycle, gnt SHALL clear, the last-grant pointer SHALL update, and the FSM SHALL return to IDLE.
REQ-013 rdata/err SHALL be valid during the done pulse and SHALL hold until the next done pulse.
REQ-014 m_done outside WAIT SHALL be ignored.
REQ-015 A req deasserted after grant SHALL NOT abort the transaction; done still pulses.
REQ-016 Latency: req asserted in IDLE with m_busy=0 SHALL produce m_start two cycles later; at least one IDLE cycle SHALL separate consecutive transactions.

Reset
REQ-017 On rst=1 all outputs SHALL be 0, the FSM SHALL be IDLE, the timeout counter 0, and the last-grant pointer 1 (requester 0 wins first).
REQ-018 rst mid-transaction SHALL abandon the transaction without a done pulse.

Structure
REQ-019 Package i2c_arb_pkg SHALL hold the state enum, NUM_REQ, and the address/data width constants.
REQ-020 The round-robin pointer and select logic SHALL be one sub-module, rr_arb2; the FSM, latches and timeout counter SHALL stay in i2c_req_arbiter.

Verification
REQ-021 req=01, rw0=0, dev 0x50, reg 0x00, wdata 0xA5, m_done after 20 cycles with ack_err=0 -> m_start 2 cycles after req, m_wdata=0xA5, done=01, err=0.
REQ-022 req=11 held, four transactions -> gnt order 01,10,01,10.
REQ-023 Read from r1, m_rdata=0x3C, m_ack_err=1 -> done=10, rdata=0x3C, err=1.
REQ-024 TIMEOUT_CYCLES=16, no m_done -> done pulses 16 cycles after m_start, err=1, rdata=0x00.
REQ-025 m_busy=1 for 5 cycles in ISSUE -> m_start is delayed and then pulses once; rst asserted in WAIT -> all outputs 0, no done pulse, next grant goes to r0.
